// File: rtl/bus_mn_s1_rr.sv
// -----------------------------------------------------------------------------
// bus_mn_s1_rr
// N-master / 1-slave interconnect for the serial system bus.
//
// Arbitrates the per-master bus requests with rotating (round-robin) priority.
// An optional tenure watchdog can force a release. While a grant is active, the
// owner's serial wdata/mode/mvalid are routed to the slave. Slave rdata/svalid
// are returned to the owner only.
//
// Parameters
//   NUM_MASTERS  number of master ports (2..16)
//   MAX_TENURE   max cycles one grant may be held; 0 disables the watchdog
//   TENURE_W     width of the tenure counter (MAX_TENURE < 2**TENURE_W)
//   OWNER_W      derived width of owner_id
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   m_wdata/m_mode/m_mvalid   per-master serial write bit, mode, valid
//   m_breq                    per-master bus request
//   m_rdata/m_svalid          per-master read bit and valid (owner only)
//   m_bgrant                  per-master grant, one-hot or zero
//   s_rdata/s_svalid/s_ready  slave read bit, read valid, slave idle
//   s_wdata/s_mode/s_mvalid   routed write bit, mode, valid to the slave
//   owner_id, bus_busy        current owner index, grant active
//   tenure_tout               one-cycle pulse when the watchdog forces release
// -----------------------------------------------------------------------------
module bus_mn_s1_rr #(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_TENURE  = 0,
    parameter int TENURE_W    = 16,
    localparam int OWNER_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_MASTERS-1:0] m_wdata,
    input  logic [NUM_MASTERS-1:0] m_mode,
    input  logic [NUM_MASTERS-1:0] m_mvalid,
    input  logic [NUM_MASTERS-1:0] m_breq,
    output logic [NUM_MASTERS-1:0] m_rdata,
    output logic [NUM_MASTERS-1:0] m_svalid,
    output logic [NUM_MASTERS-1:0] m_bgrant,
    input  logic                   s_rdata,
    input  logic                   s_svalid,
    input  logic                   s_ready,
    output logic                   s_wdata,
    output logic                   s_mode,
    output logic                   s_mvalid,
    output logic [OWNER_W-1:0]     owner_id,
    output logic                   bus_busy,
    output logic                   tenure_tout
);

    localparam bit                WD_EN       = (MAX_TENURE != 0);
    localparam logic [TENURE_W-1:0] TENURE_LAST =
        TENURE_W'((MAX_TENURE > 0) ? (MAX_TENURE - 1) : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [OWNER_W-1:0]     owner_reg;
    logic [OWNER_W-1:0]     last_owner_reg;
    logic [NUM_MASTERS-1:0] grant_reg;
    logic [NUM_MASTERS-1:0] tout_mask_reg;
    logic [TENURE_W-1:0]    tenure_reg;
    logic                   busy_reg;
    logic                   tout_reg;

    // ---------------------------------------------------------------- arbiter
    logic [NUM_MASTERS-1:0] eligible;
    logic                   pick_valid;
    logic [OWNER_W-1:0]     pick_idx;
    logic [OWNER_W-1:0]     cand_idx;
    int                     cand;
    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [NUM_MASTERS-1:0] owner_onehot;

    // Scan from the farthest offset down to last_owner+1 so the nearest
    // requester after the previous owner is the one left standing. The
    // previous owner itself (offset NUM_MASTERS) therefore ranks lowest.
    always_comb begin
        eligible   = m_breq & ~tout_mask_reg;
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int off = NUM_MASTERS; off >= 1; off--) begin
            cand     = (int'(last_owner_reg) + off) % NUM_MASTERS;
            cand_idx = OWNER_W'(cand);
            if (eligible[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_onehot
            assign pick_onehot[gi]  = (pick_idx == OWNER_W'(gi));
            assign owner_onehot[gi] = (owner_reg == OWNER_W'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= IDLE;
            owner_reg      <= '0;
            last_owner_reg <= OWNER_W'(NUM_MASTERS - 1);
            grant_reg      <= '0;
            tout_mask_reg  <= '0;
            tenure_reg     <= '0;
            busy_reg       <= 1'b0;
            tout_reg       <= 1'b0;
        end else begin
            tout_reg      <= 1'b0;
            // A timed-out master is locked out until it drops its request.
            tout_mask_reg <= tout_mask_reg & m_breq;
            case (state_reg)
                IDLE: begin
                    if (pick_valid && s_ready) begin
                        owner_reg  <= pick_idx;
                        grant_reg  <= pick_onehot;
                        busy_reg   <= 1'b1;
                        tenure_reg <= '0;
                        state_reg  <= OWNED;
                    end
                end
                OWNED: begin
                    tenure_reg <= tenure_reg + 1'b1;
                    if (!m_breq[owner_reg]) begin
                        grant_reg      <= '0;
                        busy_reg       <= 1'b0;
                        last_owner_reg <= owner_reg;
                        state_reg      <= TURN;
                    end else if (WD_EN && (tenure_reg == TENURE_LAST)) begin
                        grant_reg      <= '0;
                        busy_reg       <= 1'b0;
                        tout_reg       <= 1'b1;
                        tout_mask_reg  <= (tout_mask_reg & m_breq) | owner_onehot;
                        last_owner_reg <= owner_reg;
                        state_reg      <= TURN;
                    end
                end
                TURN: begin
                    tenure_reg <= '0;
                    state_reg  <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // --------------------------------------------------------------- datapath
    // Routing is combinational on the registered owner, so an async reset
    // removes s_mvalid from the slave in the same cycle.
    assign s_wdata  = busy_reg & m_wdata[owner_reg];
    assign s_mode   = busy_reg & m_mode[owner_reg];
    assign s_mvalid = busy_reg & m_mvalid[owner_reg];

    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_ret
            assign m_rdata[gi]  = busy_reg & owner_onehot[gi] & s_rdata;
            assign m_svalid[gi] = busy_reg & owner_onehot[gi] & s_svalid;
        end
    endgenerate

    assign m_bgrant    = grant_reg;
    assign owner_id    = owner_reg;
    assign bus_busy    = busy_reg;
    assign tenure_tout = tout_reg;

endmodule

// File: tb/tb_bus_mn_s1_rr.sv
// -----------------------------------------------------------------------------
// tb_bus_mn_s1_rr
// Bench for bus_mn_s1_rr with 4 masters. A behavioural slave with a 12-bit
// address / 8-bit data memory decodes the routed serial frames. A second
// instance with MAX_TENURE=8 exercises the tenure watchdog.
// Frame format: write = 12 addr bits + 8 data bits MSB first, mode=1;
//               read  = 12 addr bits, mode=0, slave answers 8 bits MSB first.
// -----------------------------------------------------------------------------
module tb_bus_mn_s1_rr;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] m_wdata = '0, m_mode = '0, m_mvalid = '0, m_breq = '0;
    logic [3:0] m_rdata, m_svalid, m_bgrant;
    logic       s_rdata, s_svalid, s_ready;
    logic       s_wdata, s_mode, s_mvalid;
    logic [1:0] owner_id;
    logic       bus_busy, tenure_tout;

    logic [3:0] wd_breq = '0;
    logic [3:0] wd_rdata, wd_svalid, wd_bgrant;
    logic       wd_swdata, wd_smode, wd_smvalid;
    logic [1:0] wd_owner;
    logic       wd_busy, wd_tout;

    int errors = 0;
    int checks = 0;
    int viol   = 0;

    int               grant_q[$];
    logic [7:0]       rd_q[$];
    logic [19:0]      wr_q[$];

    always #5 clk = ~clk;

    bus_mn_s1_rr #(.NUM_MASTERS(N), .MAX_TENURE(0), .TENURE_W(16)) dut (
        .clk(clk), .rstn(rstn),
        .m_wdata(m_wdata), .m_mode(m_mode), .m_mvalid(m_mvalid), .m_breq(m_breq),
        .m_rdata(m_rdata), .m_svalid(m_svalid), .m_bgrant(m_bgrant),
        .s_rdata(s_rdata), .s_svalid(s_svalid), .s_ready(s_ready),
        .s_wdata(s_wdata), .s_mode(s_mode), .s_mvalid(s_mvalid),
        .owner_id(owner_id), .bus_busy(bus_busy), .tenure_tout(tenure_tout)
    );

    bus_mn_s1_rr #(.NUM_MASTERS(N), .MAX_TENURE(8), .TENURE_W(16)) dut_wd (
        .clk(clk), .rstn(rstn),
        .m_wdata(m_wdata), .m_mode(m_mode), .m_mvalid(m_mvalid), .m_breq(wd_breq),
        .m_rdata(wd_rdata), .m_svalid(wd_svalid), .m_bgrant(wd_bgrant),
        .s_rdata(1'b0), .s_svalid(1'b0), .s_ready(1'b1),
        .s_wdata(wd_swdata), .s_mode(wd_smode), .s_mvalid(wd_smvalid),
        .owner_id(wd_owner), .bus_busy(wd_busy), .tenure_tout(wd_tout)
    );

    // ------------------------------------------------------ behavioural slave
    logic [7:0]  mem [0:4095];
    logic [19:0] sh;
    int          cnt;
    logic        rd_active;
    int          rd_cnt;
    logic [7:0]  rd_byte;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= 0; rd_active <= 1'b0; rd_cnt <= 0; sh <= '0;
            s_rdata <= 1'b0; s_svalid <= 1'b0; s_ready <= 1'b1; rd_byte <= '0;
        end else begin
            s_svalid <= 1'b0;
            s_rdata  <= 1'b0;
            if (rd_active) begin
                s_svalid <= 1'b1;
                s_rdata  <= rd_byte[7 - rd_cnt];
                rd_cnt   <= rd_cnt + 1;
                if (rd_cnt == 7) begin
                    rd_active <= 1'b0;
                    s_ready   <= 1'b1;
                end
            end else if (s_mvalid) begin
                sh      <= {sh[18:0], s_wdata};
                cnt     <= cnt + 1;
                s_ready <= 1'b0;
                if (s_mode && cnt == 19) begin
                    mem[sh[18:7]] <= {sh[6:0], s_wdata};
                    cnt     <= 0;
                    s_ready <= 1'b1;
                end else if (!s_mode && cnt == 11) begin
                    rd_byte   <= mem[{sh[10:0], s_wdata}];
                    rd_active <= 1'b1;
                    rd_cnt    <= 0;
                    cnt       <= 0;
                end
            end
        end
    end

    // Protocol monitor: routed/returned signals only while owned, one-hot grant.
    always @(negedge clk) begin
        if (rstn) begin
            if (!bus_busy && s_mvalid) viol <= viol + 1;
            if ((m_svalid & ~m_bgrant) != 4'b0) viol <= viol + 1;
            if ((m_rdata & ~m_bgrant) != 4'b0) viol <= viol + 1;
            if ($countones(m_bgrant) > 1 || $countones(wd_bgrant) > 1) viol <= viol + 1;
            if ((m_bgrant != 4'b0) != bus_busy) viol <= viol + 1;
        end
    end

    // ------------------------------------------------------------------ tasks
    task automatic apply_reset();
        @(negedge clk);
        rstn = 1'b0;
        m_breq = '0; m_mvalid = '0; m_wdata = '0; m_mode = '0; wd_breq = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_any_grant(output int who, output int gap);
        who = -1;
        gap = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (m_bgrant != 4'b0) begin
                for (int i = 0; i < N; i++) if (m_bgrant[i]) who = i;
                break;
            end
            gap++;
        end
    endtask

    // Called at a negedge with the grant visible; returns at the negedge
    // after the last bit has been sampled.
    task automatic send_bits(input int idx, input logic [19:0] bits,
                             input int nbits, input logic mode);
        for (int b = nbits - 1; b >= 0; b--) begin
            m_wdata[idx]  = bits[b];
            m_mode[idx]   = mode;
            m_mvalid[idx] = 1'b1;
            @(negedge clk);
        end
        m_mvalid[idx] = 1'b0;
        m_wdata[idx]  = 1'b0;
    endtask

    task automatic do_write(input int idx, input logic [11:0] addr, input logic [7:0] data);
        send_bits(idx, {addr, data}, 20, 1'b1);
        m_breq[idx] = 1'b0;
        m_mode[idx] = 1'b0;
        $display("write m%0d addr=%h data=%h", idx, addr, data);
    endtask

    task automatic do_read(input int idx, input logic [11:0] addr,
                           output logic [7:0] got, output int nb);
        send_bits(idx, {8'h00, addr}, 12, 1'b0);
        got = '0;
        nb  = 0;
        for (int c = 0; c < 40 && nb < 8; c++) begin
            @(negedge clk);
            if (m_svalid[idx]) begin
                got = {got[6:0], m_rdata[idx]};
                nb++;
            end
        end
        m_breq[idx] = 1'b0;
        $display("read  m%0d addr=%h data=%h bits=%0d", idx, addr, got, nb);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (m_bgrant !== 4'b0) begin errors++; $display("FAIL reset_grant got=%b want=0000", m_bgrant); end
        checks++; if (bus_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus_busy); end
        checks++; if (owner_id !== 2'd0) begin errors++; $display("FAIL reset_owner got=%0d want=0", owner_id); end
        checks++; if (tenure_tout !== 1'b0) begin errors++; $display("FAIL reset_tout got=%b want=0", tenure_tout); end
        checks++; if (s_mvalid !== 1'b0 || m_svalid !== 4'b0) begin errors++; $display("FAIL reset_route s_mvalid=%b m_svalid=%b want=0", s_mvalid, m_svalid); end
        checks++; if (wd_bgrant !== 4'b0) begin errors++; $display("FAIL reset_wd_grant got=%b want=0000", wd_bgrant); end
        rstn = 1'b1;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_first_grant();
        m_breq = 4'b0001;
        #1;
        checks++; if (m_bgrant !== 4'b0) begin errors++; $display("FAIL grant_early got=%b want=0000", m_bgrant); end
        @(negedge clk);
        checks++; if (m_bgrant !== 4'b0001) begin errors++; $display("FAIL first_grant got=%b want=0001", m_bgrant); end
        checks++; if (owner_id !== 2'd0) begin errors++; $display("FAIL first_owner got=%0d want=0", owner_id); end
        checks++; if (bus_busy !== 1'b1) begin errors++; $display("FAIL first_busy got=%b want=1", bus_busy); end
        m_breq = 4'b0;
        @(negedge clk);
        checks++; if (m_bgrant !== 4'b0) begin errors++; $display("FAIL first_release got=%b want=0000", m_bgrant); end
        @(negedge clk);
        $display("first grant m0 done");
    endtask

    task automatic test_rr_order();
        int who, gap, exp_who;
        logic [19:0] e;
        apply_reset();
        for (int k = 0; k < 4; k++) grant_q.push_back(k);
        m_breq = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_any_grant(who, gap);
            exp_who = grant_q.pop_front();
            checks++; if (who !== exp_who) begin errors++; $display("FAIL rr_order got=%0d want=%0d", who, exp_who); end
            if (k > 0) begin
                checks++; if (gap !== 2) begin errors++; $display("FAIL rr_gap got=%0d want=2", gap); end
            end
            if (who >= 0) begin
                wr_q.push_back({12'h100 + 12'(k), 8'hC0 + 8'(k)});
                do_write(who, 12'h100 + 12'(k), 8'hC0 + 8'(k));
            end
        end
        repeat (3) @(negedge clk);
        while (wr_q.size() > 0) begin
            e = wr_q.pop_front();
            checks++; if (mem[e[19:8]] !== e[7:0]) begin errors++; $display("FAIL rr_mem addr=%h got=%h want=%h", e[19:8], mem[e[19:8]], e[7:0]); end
        end
    endtask

    task automatic test_rr_priority();
        int who, gap, exp_who;
        apply_reset();
        m_breq = 4'b0010;
        wait_any_grant(who, gap);
        checks++; if (who !== 1) begin errors++; $display("FAIL prio_first got=%0d want=1", who); end
        m_breq[0] = 1'b1;
        m_breq[2] = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (m_bgrant !== 4'b0010) begin errors++; $display("FAIL prio_hold got=%b want=0010", m_bgrant); end
        grant_q.push_back(2);
        grant_q.push_back(0);
        m_breq[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wait_any_grant(who, gap);
            exp_who = grant_q.pop_front();
            checks++; if (who !== exp_who) begin errors++; $display("FAIL prio_order got=%0d want=%0d", who, exp_who); end
            $display("grant m%0d after release", who);
            if (who >= 0) m_breq[who] = 1'b0;
        end
        m_breq = 4'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_read_write();
        int who, gap, nb;
        logic [7:0] got, exp_d;
        m_breq[2] = 1'b1;
        wait_any_grant(who, gap);
        checks++; if (who !== 2) begin errors++; $display("FAIL rw_wgrant got=%0d want=2", who); end
        if (who == 2) do_write(2, 12'h3C0, 8'hA5);
        m_breq = 4'b0;
        repeat (3) @(negedge clk);
        m_breq[2] = 1'b1;
        wait_any_grant(who, gap);
        checks++; if (who !== 2) begin errors++; $display("FAIL rw_rgrant got=%0d want=2", who); end
        rd_q.push_back(8'hA5);
        got = '0; nb = 0;
        if (who == 2) do_read(2, 12'h3C0, got, nb);
        m_breq = 4'b0;
        exp_d = rd_q.pop_front();
        checks++; if (nb !== 8 || got !== exp_d) begin errors++; $display("FAIL rw_data got=%h bits=%0d want=%h bits=8", got, nb, exp_d); end
        repeat (3) @(negedge clk);
        checks++; if (viol !== 0) begin errors++; $display("FAIL rw_isolation got=%0d violations want=0", viol); end
    endtask

    task automatic test_watchdog();
        int g0_early, g0_locked, tout_n, first_tt, first_g3;
        logic g0_regrant;
        g0_early = 0; g0_locked = 0; tout_n = 0; first_tt = -1; first_g3 = -1;
        g0_regrant = 1'b0;
        wd_breq = 4'b1001;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c <= 19 && wd_bgrant[0]) g0_early++;
            if (c >= 10 && c <= 22 && wd_bgrant[0]) g0_locked++;
            if (c == 23) g0_regrant = wd_bgrant[0];
            if (wd_tout) begin
                tout_n++;
                if (first_tt < 0) first_tt = c;
            end
            if (wd_bgrant[3] && first_g3 < 0) first_g3 = c;
            if (c == 14) wd_breq[3] = 1'b0;
            if (c == 20) wd_breq[0] = 1'b0;
            if (c == 22) wd_breq[0] = 1'b1;
        end
        wd_breq = 4'b0;
        checks++; if (g0_early !== 8) begin errors++; $display("FAIL wd_tenure got=%0d cycles want=8", g0_early); end
        checks++; if (tout_n !== 1) begin errors++; $display("FAIL wd_tout_pulses got=%0d want=1", tout_n); end
        checks++; if (first_g3 - first_tt !== 2) begin errors++; $display("FAIL wd_next_grant got=%0d cycles want=2", first_g3 - first_tt); end
        checks++; if (g0_locked !== 0) begin errors++; $display("FAIL wd_lockout got=%0d grant cycles want=0", g0_locked); end
        checks++; if (g0_regrant !== 1'b1) begin errors++; $display("FAIL wd_regrant got=%b want=1", g0_regrant); end
        $display("watchdog m0 tenure=%0d tout=%0d m3_at=%0d", g0_early, tout_n, first_g3);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int who, gap, nb;
        logic [7:0] got, exp_d;
        m_breq[1] = 1'b1;
        wait_any_grant(who, gap);
        checks++; if (who !== 1) begin errors++; $display("FAIL mid_grant got=%0d want=1", who); end
        m_mode[1] = 1'b1; m_mvalid[1] = 1'b1; m_wdata[1] = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (s_mvalid !== 1'b1) begin errors++; $display("FAIL mid_route got=%b want=1", s_mvalid); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (m_bgrant !== 4'b0) begin errors++; $display("FAIL mid_reset_grant got=%b want=0000", m_bgrant); end
        checks++; if (s_mvalid !== 1'b0) begin errors++; $display("FAIL mid_reset_mvalid got=%b want=0", s_mvalid); end
        m_mvalid = '0; m_wdata = '0; m_mode = '0; m_breq = '0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        $display("reset pulsed during m1 write");
        m_breq[1] = 1'b1;
        wait_any_grant(who, gap);
        checks++; if (who !== 1) begin errors++; $display("FAIL mid_regrant got=%0d want=1", who); end
        if (who == 1) do_write(1, 12'h055, 8'h3C);
        m_breq = 4'b0;
        repeat (3) @(negedge clk);
        m_breq[1] = 1'b1;
        wait_any_grant(who, gap);
        rd_q.push_back(8'h3C);
        got = '0; nb = 0;
        if (who == 1) do_read(1, 12'h055, got, nb);
        m_breq = 4'b0;
        exp_d = rd_q.pop_front();
        checks++; if (nb !== 8 || got !== exp_d) begin errors++; $display("FAIL mid_readback got=%h bits=%0d want=%h bits=8", got, nb, exp_d); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_rr_order();
        test_rr_priority();
        test_read_write();
        test_watchdog();
        test_reset_mid();
        checks++; if (viol !== 0) begin errors++; $display("FAIL final_isolation got=%0d violations want=0", viol); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "bench timeout");
    end

endmodule
